life_engine: RTL and testbench

Parametrised Conway Game of Life core for the VGA demoscene: holds a double-buffered COLS×ROWS board in flops, computes each new generation sequentially (one cell per clock) into the back buffer, then swaps it atomically. The VGA pixel path reads the front buffer through a combinational cell-read port. The renderer maps hpos/vpos to (col, row) and drives colour from `rd_cell`.

---
 rtl/life_engine.sv | 171 +++++++++++++++++
 tb/tb_life_engine.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_engine.sv
// Conway Game of Life core (B3/S23) with a double-buffered board held in flops.
// Optional build macro LIFE_WRAP_EN makes the board toroidal; without it, off-board cells count as dead.
//
//   state  | meaning
//   IDLE   | front buffer writable; waits for step or the frame-driven auto trigger
//   SCAN   | computes one cell per clock into the back buffer and accumulates its population
//   SWAP   | flips front/back select, publishes pop_count, bumps gen_count
module life_engine #(
    parameter int COLS_LOG2  = 3,
    parameter int ROWS_LOG2  = 3,
    parameter int GEN_FRAMES = 60
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           frame_tick,
    input  logic                           run,
    input  logic                           step,
    input  logic                           wr_en,
    input  logic [COLS_LOG2-1:0]           wr_col,
    input  logic [ROWS_LOG2-1:0]           wr_row,
    input  logic                           wr_data,
    input  logic [COLS_LOG2-1:0]           rd_col,
    input  logic [ROWS_LOG2-1:0]           rd_row,
    output logic                           rd_cell,
    output logic                           busy,
    output logic [15:0]                    gen_count,
    output logic [COLS_LOG2+ROWS_LOG2:0]   pop_count
);

    localparam int COLS = 1 << COLS_LOG2;
    localparam int AW   = COLS_LOG2 + ROWS_LOG2;
    localparam int N    = 1 << AW;

    localparam logic [N-1:0]  ONE  = 1;
    localparam logic [N-1:0]  SEED = (ONE << 1) | (ONE << (COLS + 2)) | (ONE << (2 * COLS))
                                   | (ONE << (2 * COLS + 1)) | (ONE << (2 * COLS + 2));
    localparam logic [AW:0]   SEED_POP   = 5;
    localparam logic [7:0]    FRAME_LAST = 8'(GEN_FRAMES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_SWAP
    } state_t;

    state_t         state_q;
    logic [N-1:0]   bank_q [2];
    logic           front_sel_q;
    logic [AW-1:0]  k_q;
    logic [AW:0]    acc_q;
    logic [AW:0]    pop_q;
    logic [15:0]    gen_q;
    logic [7:0]     frame_q;
    logic           busy_q;

    logic [N-1:0]            front;
    logic [COLS_LOG2-1:0]    scan_col;
    logic [ROWS_LOG2-1:0]    scan_row;
    logic [COLS_LOG2-1:0]    ncol [3];
    logic [ROWS_LOG2-1:0]    nrow [3];
    logic [2:0]              col_ok;
    logic [2:0]              row_ok;
    logic [3:0]              nbr_cnt;
    logic                    next_cell;
    logic                    auto_fire;
    logic                    start;
    logic [AW-1:0]           wr_idx;

    assign front     = bank_q[front_sel_q];
    assign rd_cell   = front[{rd_row, rd_col}];
    assign busy      = busy_q;
    assign gen_count = gen_q;
    assign pop_count = pop_q;

    assign scan_col = k_q[COLS_LOG2-1:0];
    assign scan_row = k_q[AW-1:COLS_LOG2];
    assign wr_idx   = {wr_row, wr_col};

    // Neighbour coordinates wrap by truncation; the ok flags mask them off on a bounded board.
    always_comb begin
        ncol[0] = scan_col - COLS_LOG2'(1);
        ncol[1] = scan_col;
        ncol[2] = scan_col + COLS_LOG2'(1);
        nrow[0] = scan_row - ROWS_LOG2'(1);
        nrow[1] = scan_row;
        nrow[2] = scan_row + ROWS_LOG2'(1);
`ifdef LIFE_WRAP_EN
        col_ok = 3'b111;
        row_ok = 3'b111;
`else
        col_ok = {scan_col != '1, 1'b1, scan_col != '0};
        row_ok = {scan_row != '1, 1'b1, scan_row != '0};
`endif
    end

    always_comb begin
        nbr_cnt = '0;
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < 3; i++) begin
                if (!(i == 1 && j == 1) && col_ok[i] && row_ok[j] && front[{nrow[j], ncol[i]}]) begin
                    nbr_cnt = nbr_cnt + 4'd1;
                end
            end
        end
    end

    assign next_cell = (nbr_cnt == 4'd3) || (front[k_q] && (nbr_cnt == 4'd2));

    // An auto trigger that lands while busy is simply lost.
    assign auto_fire = run && frame_tick && (frame_q == FRAME_LAST);
    assign start     = (state_q == S_IDLE) && (auto_fire || (step && !run));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bank_q[0]   <= SEED;
            bank_q[1]   <= '0;
            front_sel_q <= 1'b0;
            k_q         <= '0;
            acc_q       <= '0;
            pop_q       <= SEED_POP;
            gen_q       <= '0;
            frame_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            if (!run) begin
                frame_q <= '0;
            end else if (frame_tick) begin
                frame_q <= auto_fire ? 8'd0 : frame_q + 8'd1;
            end

            case (state_q)
                S_IDLE: begin
                    if (wr_en) begin
                        bank_q[front_sel_q][wr_idx] <= wr_data;
                        if (front[wr_idx] != wr_data) begin
                            pop_q <= wr_data ? pop_q + (AW+1)'(1) : pop_q - (AW+1)'(1);
                        end
                    end
                    if (start) begin
                        state_q <= S_SCAN;
                        k_q     <= '0;
                        acc_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_SCAN: begin
                    bank_q[~front_sel_q][k_q] <= next_cell;
                    acc_q <= acc_q + (AW+1)'(next_cell);
                    if (k_q == '1) begin
                        state_q <= S_SWAP;
                    end else begin
                        k_q <= k_q + AW'(1);
                    end
                end
                S_SWAP: begin
                    front_sel_q <= ~front_sel_q;
                    pop_q       <= acc_q;
                    gen_q       <= gen_q + 16'd1;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_life_engine.sv
// Self-checking bench for life_engine: directed sequence plus random boards against a 2-D array model.
`timescale 1ns/1ps
module tb_life_engine;

    localparam int CL   = 3;
    localparam int RL   = 3;
    localparam int COLS = 8;
    localparam int ROWS = 8;
    localparam int N    = 64;
    localparam int GF   = 60;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_tick = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_col = '0;
    logic [2:0]  wr_row = '0;
    logic        wr_data = 1'b0;
    logic [2:0]  rd_col = '0;
    logic [2:0]  rd_row = '0;
    logic        rd_cell;
    logic        busy;
    logic [15:0] gen_count;
    logic [6:0]  pop_count;

    life_engine #(.COLS_LOG2(CL), .ROWS_LOG2(RL), .GEN_FRAMES(GF)) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .run(run), .step(step),
        .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row), .wr_data(wr_data),
        .rd_col(rd_col), .rd_row(rd_row), .rd_cell(rd_cell), .busy(busy),
        .gen_count(gen_count), .pop_count(pop_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int mdl [ROWS][COLS];
    int mgen = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int live(int c, int r);
`ifdef LIFE_WRAP_EN
        return mdl[(r + ROWS) % ROWS][(c + COLS) % COLS];
`else
        if (c < 0 || c >= COLS || r < 0 || r >= ROWS) return 0;
        return mdl[r][c];
`endif
    endfunction

    function automatic void model_step();
        int nxt [ROWS][COLS];
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                int n = 0;
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++)
                        if (dx != 0 || dy != 0) n += live(c + dx, r + dy);
                nxt[r][c] = (n == 3 || (mdl[r][c] == 1 && n == 2)) ? 1 : 0;
            end
        end
        mdl  = nxt;
        mgen = (mgen + 1) % 65536;
    endfunction

    function automatic int model_pop();
        int p = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) p += mdl[r][c];
        return p;
    endfunction

    function automatic logic [63:0] model_vec();
        logic [63:0] v = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) v[r * COLS + c] = (mdl[r][c] != 0);
        return v;
    endfunction

    function automatic void model_seed();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) mdl[r][c] = 0;
        mdl[0][1] = 1; mdl[1][2] = 1; mdl[2][0] = 1; mdl[2][1] = 1; mdl[2][2] = 1;
        mgen = 0;
    endfunction

    task automatic read_board(output logic [63:0] b);
        b = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                rd_col = 3'(c);
                rd_row = 3'(r);
                #1;
                b[r * COLS + c] = rd_cell;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [63:0] b;
        read_board(b);
        chk({tag, "_board"}, b, model_vec());
        chk({tag, "_pop"}, 64'(pop_count), 64'(model_pop()));
        chk({tag, "_gen"}, 64'(gen_count), 64'(mgen));
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    // Samples #1 after each edge: busy is seen for N+1 samples and the new generation is
    // already visible on the first sample where busy is low.
    task automatic do_step(input string tag);
        int cnt = 0;
        @(posedge clk); #1;
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        while (busy === 1'b1 && cnt < 200) begin
            cnt++;
            @(posedge clk); #1;
        end
        chk({tag, "_busy_cycles"}, 64'(cnt), 64'(N + 1));
        model_step();
        chk({tag, "_gen_at_fall"}, 64'(gen_count), 64'(mgen));
    endtask

    task automatic write_cell(input int c, input int r, input int v);
        wr_col = 3'(c); wr_row = 3'(r); wr_data = (v != 0); wr_en = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0;
        mdl[r][c] = (v != 0) ? 1 : 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        model_seed();
    endtask

    initial begin
        logic [63:0] expv;
        logic [15:0] g0;
        int cyc;

        do_reset();
        check_all("reset");
        expv = '0;
        expv[1] = 1'b1; expv[10] = 1'b1; expv[16] = 1'b1; expv[17] = 1'b1; expv[18] = 1'b1;
        chk("reset_seed_const", model_vec(), expv);

        for (int i = 0; i < 4; i++) do_step("glider");
        check_all("glider4");
        begin
            logic [63:0] b;
            read_board(b);
            expv = '0;
            expv[1*8+2] = 1'b1; expv[2*8+3] = 1'b1; expv[3*8+1] = 1'b1;
            expv[3*8+2] = 1'b1; expv[3*8+3] = 1'b1;
            chk("glider_shift_const", b, expv);
            chk("glider_pop_const", 64'(pop_count), 64'd5);
            chk("glider_gen_const", 64'(gen_count), 64'd4);
        end

        // A write during SCAN must be ignored.
        @(posedge clk); #1;
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        wr_col = 3'd5; wr_row = 3'd5; wr_data = (mdl[5][5] == 0); wr_en = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            @(posedge clk); #1;
        end
        chk("scan_write_done", 64'(busy), 64'd0);
        model_step();
        check_all("scan_write");

        // Reset while the scan index is 20.
        @(posedge clk); #1;
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("pre_reset_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_reset_busy", 64'(busy), 64'd0);
        model_seed();
        check_all("mid_reset");
        reset = 1'b0;

`ifdef LIFE_WRAP_EN
        for (int i = 0; i < 32; i++) do_step("wrap32");
        begin
            logic [63:0] b;
            read_board(b);
            expv = '0;
            expv[1] = 1'b1; expv[10] = 1'b1; expv[16] = 1'b1; expv[17] = 1'b1; expv[18] = 1'b1;
            chk("wrap32_seed", b, expv);
            chk("wrap32_gen", 64'(gen_count), 64'd32);
        end
        check_all("wrap32");
`endif

        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) write_cell(c, r, 0);
        chk("clear_pop", 64'(pop_count), 64'd0);
        write_cell(6, 6, 1);
        chk("wr_set_pop", 64'(pop_count), 64'd1);
        write_cell(6, 6, 1);
        chk("wr_same_pop", 64'(pop_count), 64'd1);
        write_cell(6, 6, 0);
        chk("wr_clr_pop", 64'(pop_count), 64'd0);

        write_cell(3, 0, 1);
        write_cell(4, 0, 1);
        write_cell(5, 0, 1);
        check_all("blinker_pre");
        do_step("blinker");
        check_all("blinker");
        begin
            logic [63:0] b;
            read_board(b);
            expv = '0;
            expv[4] = 1'b1; expv[12] = 1'b1;
`ifdef LIFE_WRAP_EN
            expv[60] = 1'b1;
            chk("blinker_pop_const", 64'(pop_count), 64'd3);
`else
            chk("blinker_pop_const", 64'(pop_count), 64'd2);
`endif
            chk("blinker_board_const", b, expv);
        end

        for (int it = 0; it < 4; it++) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) write_cell(c, r, ($urandom_range(0, 2) == 0) ? 1 : 0);
            check_all("rand_load");
            for (int s = 0; s < 2; s++) begin
                do_step("rand");
                check_all("rand_gen");
            end
        end

        // Run mode: tick every 100 cycles, random step pulses must be ignored.
        g0 = gen_count;
        run = 1'b1;
        for (int t = 1; t <= GF; t++) begin
            for (int i = 0; i < 99; i++) begin
                step = ($urandom_range(0, 9) == 0);
                @(posedge clk); #1;
            end
            step = 1'b0;
            if (t == GF) begin
                chk("run_pre60_gen", 64'(gen_count), 64'(g0));
                chk("run_pre60_busy", 64'(busy), 64'd0);
            end
            frame_tick = 1'b1;
            @(posedge clk); #1;
            frame_tick = 1'b0;
            if (t == GF) chk("run_tick60_busy", 64'(busy), 64'd1);
        end
        cyc = 0;
        while (gen_count === g0 && cyc < 200) begin
            cyc++;
            @(posedge clk); #1;
        end
        chk("run_auto_latency", 64'(cyc), 64'(N + 1));
        model_step();
        chk("run_gen", 64'(gen_count), 64'(mgen));
        run = 1'b0;
        @(posedge clk); #1;
        check_all("run_board");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
